// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches through a req/ack handshake,
// presents the instruction to the decoder and computes the next PC on retire.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [1:0]  iOrigPC,
  input  logic        iBranchTaken,
  input  logic [31:0] iImm,
  input  logic [31:0] iRs1,
  input  logic        iRetire,
  output logic [31:0] oIMemAddr,
  output logic        oIMemReq,
  input  logic        iIMemAck,
  input  logic [31:0] iIMemData,
  output logic [31:0] oInstr,
  output logic [31:0] oPC,
  output logic [31:0] oPC4,
  output logic        oInstrValid,
  output logic        oMisaligned,
  output logic        oBusErr
);

  localparam logic [31:0] NOP         = 32'h0000_0013;
  localparam logic [15:0] MAX_WAIT_C  = 16'(MAX_WAIT);
  localparam bit          TIMEOUT_EN  = (MAX_WAIT != 0);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID, S_TRAP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [15:0] wait_q, wait_d;
  logic        mis_q, mis_d;
  logic        berr_q, berr_d;

  logic [31:0] next_pc;
  logic [31:0] jalr_sum;
  logic [15:0] wait_inc;
  logic        ack_fetch;
  logic        retire_valid;
  logic        timeout;

  // Next-PC select; JALR target has bit 0 cleared before the alignment check.
  always_comb begin
    jalr_sum = iRs1 + iImm;
    next_pc  = pc_q + 32'd4;
    unique case (iOrigPC)
      2'b00:   next_pc = pc_q + 32'd4;
      2'b01:   next_pc = iBranchTaken ? (pc_q + iImm) : (pc_q + 32'd4);
      2'b10:   next_pc = pc_q + iImm;
      default: next_pc = {jalr_sum[31:1], 1'b0};
    endcase
  end

  always_comb begin
    ack_fetch    = (state_q == S_FETCH) && iIMemAck;
    retire_valid = (state_q == S_VALID) && iRetire;
    wait_inc     = (wait_q == 16'hFFFF) ? wait_q : (wait_q + 16'd1);
    timeout      = TIMEOUT_EN && (wait_inc >= MAX_WAIT_C);
  end

  // State register
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  state_d = S_FETCH;
      S_FETCH: begin
        if (iIMemAck)     state_d = S_VALID;
        else if (timeout) state_d = S_TRAP;
      end
      S_VALID: begin
        if (iRetire) state_d = next_pc[1] ? S_TRAP : S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase
  end

  // Output logic: Moore outputs decoded from registered state only
  always_comb begin
    oIMemReq    = (state_q == S_FETCH);
    oInstrValid = (state_q == S_VALID);
  end

  // Datapath and trap flags; wait counter is zero whenever not in FETCH,
  // which clears it on every FETCH entry.
  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    wait_d  = 16'd0;
    mis_d   = mis_q;
    berr_d  = berr_q;
    if (ack_fetch) instr_d = iIMemData;
    if ((state_q == S_FETCH) && !iIMemAck) begin
      wait_d = wait_inc;
      if (timeout) berr_d = 1'b1;
    end
    if (retire_valid) begin
      if (next_pc[1]) mis_d = 1'b1;
      else            pc_d  = next_pc;
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      pc_q    <= RESET_PC;
      instr_q <= NOP;
      wait_q  <= 16'd0;
      mis_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      wait_q  <= wait_d;
      mis_q   <= mis_d;
      berr_q  <= berr_d;
    end
  end

  assign oIMemAddr   = pc_q;
  assign oPC         = pc_q;
  assign oPC4        = pc_q + 32'd4;
  assign oInstr      = instr_q;
  assign oMisaligned = mis_q;
  assign oBusErr     = berr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, multi-cycle corner sequences,
// and a randomized run checked against a transaction-level next-PC model.
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int          MAX_WAIT = 15;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sel;
  logic        taken;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        retire;
  logic [31:0] addr;
  logic        req;
  logic        ack;
  logic [31:0] mdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic        ivalid;
  logic        mis;
  logic        berr;

  fetch_unit #(.RESET_PC(RESET_PC), .MAX_WAIT(MAX_WAIT)) dut (
    .iCLK(clk), .iRST(rst_n), .iOrigPC(sel), .iBranchTaken(taken),
    .iImm(imm), .iRs1(rs1), .iRetire(retire), .oIMemAddr(addr),
    .oIMemReq(req), .iIMemAck(ack), .iIMemData(mdata), .oInstr(instr),
    .oPC(pc), .oPC4(pc4), .oInstrValid(ivalid), .oMisaligned(mis),
    .oBusErr(berr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0]  sel;
    logic        taken;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic [31:0] exp_addr;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sel = 2'b00; taken = 1'b0; imm = 32'h0; rs1 = 32'h0;
    retire = 1'b0; ack = 1'b0; mdata = 32'h0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_req();
    for (int i = 0; i < 8; i++) begin
      if (req) break;
      step();
    end
    chk("req_wait", req, 1'b1);
  endtask

  // Next-PC rules as plain arithmetic on the architectural values.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [1:0] s,
                                           input logic t, input logic [31:0] im,
                                           input logic [31:0] r);
    logic [31:0] tgt;
    case (s)
      2'd0:    tgt = p + 32'd4;
      2'd1:    tgt = t ? p + im : p + 32'd4;
      2'd2:    tgt = p + im;
      default: begin
        tgt = r + im;
        tgt[0] = 1'b0;
      end
    endcase
    return tgt;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] cur;
    logic [31:0] d;
    logic [31:0] expn;
    int          cnt;
    int          n_mis;

    vecs[0]  = '{2'b00, 1'b0, 32'h0,        32'h0,        32'h0040_0004, 1'b0};
    vecs[1]  = '{2'b00, 1'b1, 32'h100,      32'h0,        32'h0040_0008, 1'b0};
    vecs[2]  = '{2'b10, 1'b0, 32'h8,        32'h0,        32'h0040_0010, 1'b0};
    vecs[3]  = '{2'b01, 1'b1, 32'hFFFF_FFF0, 32'h0,       32'h0040_0000, 1'b0};
    vecs[4]  = '{2'b10, 1'b0, 32'h10,       32'h0,        32'h0040_0010, 1'b0};
    vecs[5]  = '{2'b01, 1'b0, 32'hFFFF_FFF0, 32'h0,       32'h0040_0014, 1'b0};
    vecs[6]  = '{2'b11, 1'b0, 32'h0000_000F, 32'h0040_0101, 32'h0040_0110, 1'b0};
    vecs[7]  = '{2'b11, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 1'b0};
    vecs[8]  = '{2'b00, 1'b0, 32'h0,        32'h0,        32'h0000_0000, 1'b0};
    vecs[9]  = '{2'b01, 1'b1, 32'h0040_0000, 32'h0,       32'h0040_0000, 1'b0};
    vecs[10] = '{2'b11, 1'b0, 32'h0,        32'h0040_0002, 32'h0040_0000, 1'b1};

    // Reset values
    rst_n = 1'b0;
    idle_inputs();
    step();
    step();
    chk("rst_req", req, 1'b0);
    chk("rst_valid", ivalid, 1'b0);
    chk("rst_instr", instr, NOP);
    chk("rst_pc", pc, RESET_PC);
    chk("rst_addr", addr, RESET_PC);
    chk("rst_pc4", pc4, RESET_PC + 32'd4);
    chk("rst_mis", mis, 1'b0);
    chk("rst_berr", berr, 1'b0);
    rst_n = 1'b1;
    #1;
    chk("idle_req", req, 1'b0);
    step();
    chk("startup_req", req, 1'b1);
    chk("startup_addr", addr, RESET_PC);

    // Directed vector table, zero-wait memory and retire in the first VALID cycle
    cur = RESET_PC;
    for (int i = 0; i < 11; i++) begin
      ack = 1'b1;
      mdata = NOP ^ (32'(i) << 20);
      step();
      ack = 1'b0;
      chk("vec_valid", ivalid, 1'b1);
      chk("vec_instr", instr, NOP ^ (32'(i) << 20));
      chk("vec_pc", pc, cur);
      sel = vecs[i].sel; taken = vecs[i].taken; imm = vecs[i].imm; rs1 = vecs[i].rs1;
      retire = 1'b1;
      step();
      retire = 1'b0;
      if (vecs[i].exp_mis) begin
        chk("vec_mis", mis, 1'b1);
        chk("vec_mis_req", req, 1'b0);
        chk("vec_mis_pc", pc, cur);
        retire = 1'b1;
        ack = 1'b1;
        step();
        step();
        chk("trap_hold_req", req, 1'b0);
        chk("trap_hold_mis", mis, 1'b1);
        chk("trap_hold_pc", pc, cur);
        idle_inputs();
      end else begin
        chk("vec_req", req, 1'b1);
        chk("vec_addr", addr, vecs[i].exp_addr);
        chk("vec_valid_low", ivalid, 1'b0);
        chk("vec_mis_low", mis, 1'b0);
        cur = vecs[i].exp_addr;
      end
    end

    // Fetch timeout: ack withheld, stray retire pulses must be ignored
    do_reset();
    step();
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (!req) break;
      cnt++;
      retire = i[0];
      step();
    end
    retire = 1'b0;
    chk("berr_cycles", cnt, 32'd15);
    chk("berr_flag", berr, 1'b1);
    chk("berr_valid", ivalid, 1'b0);
    ack = 1'b1;
    mdata = 32'h1234_5678;
    step();
    step();
    ack = 1'b0;
    chk("berr_hold", berr, 1'b1);
    chk("berr_req", req, 1'b0);
    chk("berr_instr", instr, NOP);

    // Ack on the 14th FETCH cycle completes normally
    do_reset();
    step();
    for (int i = 0; i < 13; i++) begin
      chk("late_addr", addr, RESET_PC);
      step();
    end
    chk("late_req", req, 1'b1);
    ack = 1'b1;
    mdata = 32'h00A0_0093;
    step();
    ack = 1'b0;
    chk("late_valid", ivalid, 1'b1);
    chk("late_instr", instr, 32'h00A0_0093);
    step();
    step();
    chk("late_berr", berr, 1'b0);
    chk("late_hold", ivalid, 1'b1);

    // Reset asserted during FETCH while ack arrives in the same cycle
    do_reset();
    step();
    step();
    ack = 1'b1;
    mdata = 32'hDEAD_BEEF;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req", req, 1'b0);
    chk("arst_instr", instr, NOP);
    chk("arst_pc", pc, RESET_PC);
    step();
    chk("arst_instr2", instr, NOP);
    chk("arst_valid", ivalid, 1'b0);
    ack = 1'b0;
    rst_n = 1'b1;
    step();
    chk("arst_restart_req", req, 1'b1);
    chk("arst_restart_addr", addr, RESET_PC);

    // Randomized run against the next-PC model
    do_reset();
    cur = RESET_PC;
    n_mis = 0;
    for (int it = 0; it < 200; it++) begin
      wait_req();
      chk("rnd_addr", addr, cur);
      d = $urandom_range(0, MAX_WAIT - 2);
      for (int j = 0; j < int'(d); j++) begin
        retire = $urandom_range(0, 1);
        sel = 2'($urandom);
        imm = $urandom;
        step();
        chk("rnd_wait_req", req, 1'b1);
        chk("rnd_wait_addr", addr, cur);
      end
      retire = 1'b0;
      mdata = $urandom;
      d = mdata;
      ack = 1'b1;
      step();
      chk("rnd_valid", ivalid, 1'b1);
      chk("rnd_instr", instr, d);
      chk("rnd_pc", pc, cur);
      chk("rnd_pc4", pc4, cur + 32'd4);
      for (int h = 0; h < int'($urandom_range(0, 2)); h++) begin
        ack = 1'b1;
        mdata = $urandom;
        sel = 2'($urandom); taken = 1'($urandom); imm = $urandom; rs1 = $urandom;
        step();
        chk("rnd_hold_instr", instr, d);
        chk("rnd_hold_valid", ivalid, 1'b1);
      end
      ack = 1'b0;
      sel = 2'($urandom);
      taken = 1'($urandom);
      imm = $urandom;
      rs1 = $urandom;
      if ($urandom_range(0, 7) != 0) begin
        imm[1:0] = 2'b00;
        rs1[1:0] = 2'b00;
      end
      expn = ref_next(cur, sel, taken, imm, rs1);
      retire = 1'b1;
      step();
      retire = 1'b0;
      if (expn[1]) begin
        n_mis++;
        chk("rnd_mis", mis, 1'b1);
        chk("rnd_mis_req", req, 1'b0);
        chk("rnd_mis_pc", pc, cur);
        do_reset();
        cur = RESET_PC;
      end else begin
        chk("rnd_next_req", req, 1'b1);
        chk("rnd_next_addr", addr, expn);
        chk("rnd_next_mis", mis, 1'b0);
        cur = expn;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
